// File: rtl/wb_pipe_stage.sv
// Writeback pipeline stage: holds MEM-side entries and presents the selected result to the register file.
// Define WB_SKID_EN for a 2-entry skid buffer with registered in_ready; default is a single entry register.
module wb_pipe_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [REGW-1:0] rdM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ReadDataM,
    input  logic [XLEN-1:0] PCplus4M,
    input  logic [XLEN-1:0] ImmExtM,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            RegWriteW,
    output logic [REGW-1:0] rdW,
    output logic [XLEN-1:0] ResultW,
    output logic [1:0]      state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a presented entry holds until it is taken.

    typedef struct packed {
        logic            regwrite;
        logic [1:0]      src;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] mem;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t     in_entry;
    entry_t     head_q;
    logic [1:0] state_q;
    logic       accept;
    logic       retire;

    assign in_entry  = {RegWriteM, ResultSrcM, rdM, ALUResultM, ReadDataM, PCplus4M, ImmExtM};
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;
    assign state_dbg = state_q;

`ifdef WB_SKID_EN
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    entry_t skid_q;
    logic   in_ready_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        head_q  <= in_entry;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && retire) begin
                        head_q <= in_entry;
                    end else if (accept) begin
                        skid_q     <= in_entry;
                        state_q    <= S_TWO;
                        in_ready_q <= 1'b0;
                    end else if (retire) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is 0 here, so only a retire can occur; the skid entry becomes head.
                    if (retire) begin
                        head_q     <= skid_q;
                        state_q    <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
        end else if (flush) begin
            state_q <= S_EMPTY;
        end else if (accept) begin
            // Covers both a fill and an in-place replace on simultaneous retire.
            head_q  <= in_entry;
            state_q <= S_FULL;
        end else if (retire) begin
            state_q <= S_EMPTY;
        end
    end
`endif

    always_comb begin
        ResultW = head_q.alu;
        case (head_q.src)
            2'b00:   ResultW = head_q.alu;
            2'b01:   ResultW = head_q.mem;
            2'b10:   ResultW = head_q.pc4;
            default: ResultW = head_q.imm;
        endcase
    end

    assign rdW       = head_q.rd;
    assign RegWriteW = head_q.regwrite & out_valid & (|head_q.rd);

endmodule
